// File: rtl/execute_div.sv
// Iterative restoring divider for the execute stage.
// One quotient bit per cycle; signs are fixed up after the loop.
module execute_div #(
  parameter int LEN_REG = 32,
  parameter int LEN_CNT = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_i,
  input  logic [LEN_REG-1:0] data_rd,
  input  logic [LEN_REG-1:0] data_rs,
  input  logic               flush,
  output logic               busy,
  output logic               valid_o,
  output logic [LEN_REG-1:0] quot_o,
  output logic [LEN_REG-1:0] rem_o,
  output logic               div_zero_o
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam logic [LEN_REG-1:0] ONE = LEN_REG'(1);
  localparam logic [LEN_REG:0]   ONE_W = (LEN_REG+1)'(1);
  localparam logic [LEN_CNT-1:0] CNT_LOAD = LEN_CNT'(LEN_REG-1);

  state_t r_state;
  state_t w_next;

  logic [LEN_REG-1:0] r_dvd;
  logic [LEN_REG-1:0] r_dvs;
  logic [LEN_REG-1:0] r_rem;
  logic [LEN_CNT-1:0] r_cnt;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_dz;

  logic               w_accept;
  logic               w_rd_neg;
  logic               w_rs_neg;
  logic [LEN_REG-1:0] w_rd_abs;
  logic [LEN_REG-1:0] w_rs_abs;
  logic [LEN_REG:0]   w_rem_sh;
  logic [LEN_REG:0]   w_trial;
  logic               w_carry;
  logic               w_qbit;
  logic [LEN_REG-1:0] w_q_fix;
  logic [LEN_REG-1:0] w_r_fix;

  assign w_accept = (r_state == IDLE) && start && !flush;
  assign w_rd_neg = signed_i && data_rd[LEN_REG-1];
  assign w_rs_neg = signed_i && data_rs[LEN_REG-1];
  assign w_rd_abs = w_rd_neg ? (~data_rd + ONE) : data_rd;
  assign w_rs_abs = w_rs_neg ? (~data_rs + ONE) : data_rs;

  // Trial subtraction as rem + ~dvs + 1; carry-out means rem >= dvs.
  assign w_rem_sh = {r_rem, r_dvd[LEN_REG-1]};
  assign {w_carry, w_trial} = {1'b0, w_rem_sh}
                            + {1'b0, ~{1'b0, r_dvs}}
                            + {1'b0, ONE_W};
  // A taken trial is always below the divisor, so its top bit is zero.
  assign w_qbit = w_carry && !w_trial[LEN_REG];

  // Quotient stays all ones on divide by zero.
  assign w_q_fix = (r_sign_q && !r_dz) ? (~r_dvd + ONE) : r_dvd;
  assign w_r_fix = r_sign_r ? (~r_rem + ONE) : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start && !flush) w_next = CALC;
      end
      CALC: begin
        if (flush)           w_next = IDLE;
        else if (r_cnt == 0) w_next = FIX;
      end
      FIX: begin
        w_next = flush ? IDLE : DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    valid_o = 1'b0;
    unique case (r_state)
      IDLE: busy = 1'b0;
      CALC: busy = 1'b1;
      FIX:  busy = 1'b1;
      DONE: begin
        busy    = 1'b1;
        valid_o = !flush;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
    end else if (w_accept) begin
      r_dvd    <= w_rd_abs;
      r_dvs    <= w_rs_abs;
      r_rem    <= '0;
      r_cnt    <= CNT_LOAD;
      r_sign_q <= w_rd_neg ^ w_rs_neg;
      r_sign_r <= w_rd_neg;
      r_dz     <= (data_rs == '0);
    end else if (r_state == CALC && !flush) begin
      r_dvd <= {r_dvd[LEN_REG-2:0], w_qbit};
      r_rem <= w_qbit ? w_trial[LEN_REG-1:0]
                      : w_rem_sh[LEN_REG-1:0];
      if (r_cnt != 0) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_o     <= '0;
      rem_o      <= '0;
      div_zero_o <= 1'b0;
    end else if (r_state == FIX && !flush) begin
      quot_o     <= w_q_fix;
      rem_o      <= w_r_fix;
      div_zero_o <= r_dz;
    end
  end

endmodule
